sum_toggle_monitor: RTL

//   Downstream observer of the clocked adder's registered sum bus; measures switching activity for power estimation.

---
 rtl/sum_toggle_monitor_pkg.sv | 19 +
 rtl/sum_toggle_monitor_if.sv | 29 ++
 rtl/sum_toggle_monitor_popcount.sv | 18 +
 rtl/sum_toggle_monitor.sv | 109 ++++++++++
 4 files changed

// File: rtl/sum_toggle_monitor_pkg.sv
// rtl/sum_toggle_monitor_pkg.sv - shared state encoding and width helpers for the sum toggle monitor
package sum_toggle_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_e;

  // Worst case is every bit flipping on every transition after the first sample.
  function automatic int tog_width(input int data_w, input int window);
    return $clog2(data_w * (window - 1) + 1);
  endfunction

  function automatic int smp_width(input int window);
    return $clog2(window + 1);
  endfunction

endpackage

// File: rtl/sum_toggle_monitor_if.sv
// rtl/sum_toggle_monitor_if.sv - sample input, report output and control bundle of the toggle monitor
interface sum_toggle_monitor_if #(
  parameter int DATA_W = 5,
  parameter int WINDOW = 16
);
  import sum_toggle_monitor_pkg::*;

  localparam int TOG_W = tog_width(DATA_W, WINDOW);

  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [TOG_W-1:0]  out_toggles;
  logic              out_dropped;
  logic              busy;

  modport master (
    output start, in_valid, in_data, out_ready,
    input  out_valid, out_toggles, out_dropped, busy
  );

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output out_valid, out_toggles, out_dropped, busy
  );

endinterface

// File: rtl/sum_toggle_monitor_popcount.sv
// rtl/sum_toggle_monitor_popcount.sv - combinational set-bit count of a W-bit vector
module sum_toggle_monitor_popcount #(
  parameter int W = 5
) (
  input  logic [W-1:0]             in_bits,
  output logic [$clog2(W+1)-1:0]   count
);

  localparam int CW = $clog2(W + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(in_bits[i]);
    end
  end

endmodule

// File: rtl/sum_toggle_monitor.sv
// rtl/sum_toggle_monitor.sv - counts bit toggles on a monitored bus over a fixed sample window
// and hands the total out on a valid/ready report port.
module sum_toggle_monitor
  import sum_toggle_monitor_pkg::*;
#(
  parameter int DATA_W = 5,
  parameter int WINDOW = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  sum_toggle_monitor_if.slave mon
);

  localparam int TOG_W = tog_width(DATA_W, WINDOW);
  localparam int SMP_W = smp_width(WINDOW);
  localparam int PC_W  = $clog2(DATA_W + 1);

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic              dropped_q, dropped_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [TOG_W-1:0]  tog_acc_q, tog_acc_d;
  logic [SMP_W-1:0]  smp_cnt_q, smp_cnt_d;
  logic [SMP_W-1:0]  smp_inc;
  logic [PC_W-1:0]   pop;

  sum_toggle_monitor_popcount #(.W(DATA_W)) u_popcount (
    .in_bits (mon.in_data ^ prev_q),
    .count   (pop)
  );

  assign smp_inc = smp_cnt_q + SMP_W'(1);

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    dropped_d   = dropped_q;
    prev_d      = prev_q;
    tog_acc_d   = tog_acc_q;
    smp_cnt_d   = smp_cnt_q;
    case (state_q)
      IDLE: begin
        if (mon.start) begin
          tog_acc_d = '0;
          smp_cnt_d = '0;
          dropped_d = 1'b0;
          state_d   = ACCUM;
        end
      end
      ACCUM: begin
        if (mon.in_valid) begin
          // The first sample only seeds prev; there is nothing to compare it with.
          prev_d = mon.in_data;
          if (smp_cnt_q != '0) begin
            tog_acc_d = tog_acc_q + TOG_W'(pop);
          end
          smp_cnt_d = smp_inc;
          if (smp_inc == SMP_W'(WINDOW)) begin
            state_d     = REPORT;
            out_valid_d = 1'b1;
          end
        end
      end
      REPORT: begin
        if (mon.in_valid) begin
          dropped_d = 1'b1;
        end
        if (mon.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dropped_q <= 1'b0;
      prev_q    <= '0;
      tog_acc_q <= '0;
      smp_cnt_q <= '0;
    end else begin
      dropped_q <= dropped_d;
      prev_q    <= prev_d;
      tog_acc_q <= tog_acc_d;
      smp_cnt_q <= smp_cnt_d;
    end
  end

  assign mon.out_valid   = out_valid_q;
  assign mon.out_toggles = tog_acc_q;
  assign mon.out_dropped = dropped_q;
  assign mon.busy        = (state_q != IDLE);

endmodule
